// File: rtl/sdr_init_seq_pkg.sv
// Shared encodings for the SDRAM power-up init sequencer (states, commands, helpers).
// The optional EMR states are only reachable when SDR_INIT_EMR_EN is defined.
package sdr_init_pkg;

  // Legacy state encodings; the enum below reuses them so existing decoders keep working.
  localparam logic [3:0] ST_RST      = 4'd0;
  localparam logic [3:0] ST_WAIT_PWR = 4'd1;
  localparam logic [3:0] ST_PRE      = 4'd2;
  localparam logic [3:0] ST_WAIT_RP  = 4'd3;
  localparam logic [3:0] ST_AREF     = 4'd4;
  localparam logic [3:0] ST_WAIT_RFC = 4'd5;
  localparam logic [3:0] ST_LMR      = 4'd6;
  localparam logic [3:0] ST_WAIT_MRD = 4'd7;
  localparam logic [3:0] ST_DONE     = 4'd8;
  localparam logic [3:0] ST_EMR      = 4'd9;
  localparam logic [3:0] ST_WAIT_EMR = 4'd10;

  typedef enum logic [3:0] {
    S_RST      = ST_RST,
    S_WAIT_PWR = ST_WAIT_PWR,
    S_PRE      = ST_PRE,
    S_WAIT_RP  = ST_WAIT_RP,
    S_AREF     = ST_AREF,
    S_WAIT_RFC = ST_WAIT_RFC,
    S_LMR      = ST_LMR,
    S_WAIT_MRD = ST_WAIT_MRD,
    S_DONE     = ST_DONE,
    S_EMR      = ST_EMR,
    S_WAIT_EMR = ST_WAIT_EMR
  } state_t;

  // {ras_n, cas_n, we_n}
  localparam logic [2:0] CMD_NOP  = 3'b111;
  localparam logic [2:0] CMD_PRE  = 3'b010;
  localparam logic [2:0] CMD_AREF = 3'b001;
  localparam logic [2:0] CMD_LMR  = 3'b000;

  typedef enum logic [2:0] {
    C_NOP  = CMD_NOP,
    C_PRE  = CMD_PRE,
    C_AREF = CMD_AREF,
    C_LMR  = CMD_LMR
  } cmd_t;

  localparam int unsigned A10_BIT = 10;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic cmd_t state_cmd(input state_t s);
    case (s)
      S_PRE:        return C_PRE;
      S_AREF:       return C_AREF;
      S_LMR, S_EMR: return C_LMR;
      default:      return C_NOP;
    endcase
  endfunction

endpackage

// File: rtl/sdr_init_seq_if.sv
// SDRAM command/address pin bundle; master drives the pins, slave observes them.
interface sdr_init_seq_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned BA_W   = 2
);
  logic              sdr_cke;
  logic              sdr_cs_n;
  logic              sdr_ras_n;
  logic              sdr_cas_n;
  logic              sdr_we_n;
  logic [ADDR_W-1:0] sdr_addr;
  logic [BA_W-1:0]   sdr_ba;

  modport master (
    output sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_addr, sdr_ba
  );

  modport slave (
    input sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_addr, sdr_ba
  );
endinterface

// File: rtl/sdr_init_seq_cmd_drv.sv
// Registered output stage: maps the upcoming state and command onto the SDRAM pins
// and the done/busy flags, so every pin changes on the same edge as the FSM state.
module sdr_cmd_drv
  import sdr_init_pkg::*;
#(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned BA_W   = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  state_t            i_state,
  input  cmd_t              i_cmd,
  input  logic [ADDR_W-1:0] i_lmr_addr,
  input  logic [BA_W-1:0]   i_lmr_ba,
  output logic              o_init_done,
  output logic              o_init_busy,
  sdr_init_seq_if.master    o_bus
);

  logic [ADDR_W-1:0] w_addr;
  logic [BA_W-1:0]   w_ba;

  always_comb begin
    w_addr = '0;
    w_ba   = '0;
    if (i_cmd == C_LMR) begin
      w_addr = i_lmr_addr;
      w_ba   = i_lmr_ba;
    end else if (i_cmd == C_PRE) begin
      w_addr[A10_BIT] = 1'b1;
    end
  end

  // Reset leaves the pins deselected with ras/cas/we low, so the first NOP is a visible edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_bus.sdr_cke   <= 1'b0;
      o_bus.sdr_cs_n  <= 1'b1;
      o_bus.sdr_ras_n <= 1'b0;
      o_bus.sdr_cas_n <= 1'b0;
      o_bus.sdr_we_n  <= 1'b0;
      o_bus.sdr_addr  <= '0;
      o_bus.sdr_ba    <= '0;
      o_init_done     <= 1'b0;
      o_init_busy     <= 1'b1;
    end else begin
      o_bus.sdr_cke   <= 1'b1;
      o_bus.sdr_cs_n  <= 1'b0;
      {o_bus.sdr_ras_n, o_bus.sdr_cas_n, o_bus.sdr_we_n} <= i_cmd;
      o_bus.sdr_addr  <= w_addr;
      o_bus.sdr_ba    <= w_ba;
      o_init_done     <= (i_state == S_DONE);
      o_init_busy     <= (i_state != S_DONE);
    end
  end

endmodule

// File: rtl/sdr_init_seq.sv
// SDRAM power-up init sequencer: NOP hold, PRECHARGE-ALL, NUM_AREF refreshes, LMR.
// Define SDR_INIT_EMR_EN to append an extended-mode-register load (ba=1) after the LMR.
module sdr_init_seq
  import sdr_init_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 600,
  parameter int unsigned T_RP        = 3,
  parameter int unsigned T_RFC       = 7,
  parameter int unsigned T_MRD       = 2,
  parameter int unsigned NUM_AREF    = 2,
  parameter int unsigned SDR_ADDR_W  = 13,
  parameter int unsigned SDR_BA_W    = 2
) (
  input  logic                  sdram_clk,
  input  logic                  sdram_reset,
  input  logic                  init_req,
  input  logic [SDR_ADDR_W-1:0] cfg_mode_reg,
  input  logic [SDR_ADDR_W-1:0] cfg_ext_mode_reg,
  output logic                  init_done,
  output logic                  init_busy,
  sdr_init_seq_if.master        sdr
);

  localparam int unsigned CNT_MAX = max_u(max_u(WAIT_CYCLES, T_RFC), max_u(T_RP, T_MRD));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  // Wait-state lengths: a command occupies one cycle, so T_x leaves T_x-1 NOPs.
  localparam logic [CNT_W-1:0] L_PWR   = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] L_RP    = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] L_RFC   = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] L_MRD   = CNT_W'(T_MRD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [3:0]       AREF_N  = 4'(NUM_AREF);

`ifdef SDR_INIT_EMR_EN
  localparam state_t MRD_EXIT = S_EMR;
`else
  localparam state_t MRD_EXIT = S_DONE;
`endif

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [3:0]            r_aref, w_aref_nxt;
  cmd_t                  w_cmd;
  logic [SDR_ADDR_W-1:0] w_lmr_addr;
  logic [SDR_BA_W-1:0]   w_lmr_ba;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt != '0) ? r_cnt - CNT_ONE : '0;
    w_aref_nxt  = r_aref;
    case (r_state)
      S_RST: begin
        w_state_nxt = S_WAIT_PWR;
        w_cnt_nxt   = L_PWR;
      end
      S_WAIT_PWR: if (r_cnt <= CNT_ONE) w_state_nxt = S_PRE;
      S_PRE: begin
        if (L_RP == '0) w_state_nxt = S_AREF;
        else begin
          w_state_nxt = S_WAIT_RP;
          w_cnt_nxt   = L_RP;
        end
      end
      S_WAIT_RP: if (r_cnt <= CNT_ONE) w_state_nxt = S_AREF;
      S_AREF: begin
        w_aref_nxt = r_aref + 4'd1;
        if (L_RFC == '0) w_state_nxt = (w_aref_nxt < AREF_N) ? S_AREF : S_LMR;
        else begin
          w_state_nxt = S_WAIT_RFC;
          w_cnt_nxt   = L_RFC;
        end
      end
      S_WAIT_RFC: if (r_cnt <= CNT_ONE) w_state_nxt = (r_aref < AREF_N) ? S_AREF : S_LMR;
      S_LMR: begin
        if (L_MRD == '0) w_state_nxt = MRD_EXIT;
        else begin
          w_state_nxt = S_WAIT_MRD;
          w_cnt_nxt   = L_MRD;
        end
      end
      S_WAIT_MRD: if (r_cnt <= CNT_ONE) w_state_nxt = MRD_EXIT;
`ifdef SDR_INIT_EMR_EN
      S_EMR: begin
        if (L_MRD == '0) w_state_nxt = S_DONE;
        else begin
          w_state_nxt = S_WAIT_EMR;
          w_cnt_nxt   = L_MRD;
        end
      end
      S_WAIT_EMR: if (r_cnt <= CNT_ONE) w_state_nxt = S_DONE;
`endif
      S_DONE: begin
        if (init_req) begin
          w_state_nxt = S_PRE;
          w_aref_nxt  = '0;
        end
      end
      default: w_state_nxt = S_RST;
    endcase
  end

  always_ff @(posedge sdram_clk) begin
    if (sdram_reset) begin
      r_state <= S_RST;
      r_cnt   <= '0;
      r_aref  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_aref  <= w_aref_nxt;
    end
  end

  // The driver registers the next-state decode so pins line up with r_state.
  assign w_cmd = state_cmd(w_state_nxt);

`ifdef SDR_INIT_EMR_EN
  assign w_lmr_addr = (w_state_nxt == S_EMR) ? cfg_ext_mode_reg : cfg_mode_reg;
  assign w_lmr_ba   = (w_state_nxt == S_EMR) ? SDR_BA_W'(1) : '0;
`else
  logic w_unused_ext;
  assign w_unused_ext = ^cfg_ext_mode_reg;
  assign w_lmr_addr   = cfg_mode_reg;
  assign w_lmr_ba     = '0;
`endif

  sdr_cmd_drv #(
    .ADDR_W (SDR_ADDR_W),
    .BA_W   (SDR_BA_W)
  ) u_cmd_drv (
    .i_clk       (sdram_clk),
    .i_rst       (sdram_reset),
    .i_state     (w_state_nxt),
    .i_cmd       (w_cmd),
    .i_lmr_addr  (w_lmr_addr),
    .i_lmr_ba    (w_lmr_ba),
    .o_init_done (init_done),
    .o_init_busy (init_busy),
    .o_bus       (sdr)
  );

endmodule

// File: tb/tb_sdr_init_seq.sv
// Directed bench for sdr_init_seq: walks the full command timeline cycle by cycle
// against a hand-written table keyed on the cycle index after reset release.
module tb_sdr_init_seq;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        init_req = 1'b0;
  logic [12:0] mode_reg = 13'h0033;
  logic [12:0] ext_reg  = 13'h0002;
  logic        done;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  sdr_init_seq_if #(.ADDR_W(13), .BA_W(2)) bus ();

  sdr_init_seq #(
    .WAIT_CYCLES (600),
    .T_RP        (3),
    .T_RFC       (7),
    .T_MRD       (2),
    .NUM_AREF    (2),
    .SDR_ADDR_W  (13),
    .SDR_BA_W    (2)
  ) dut (
    .sdram_clk        (clk),
    .sdram_reset      (rst),
    .init_req         (init_req),
    .cfg_mode_reg     (mode_reg),
    .cfg_ext_mode_reg (ext_reg),
    .init_done        (done),
    .init_busy        (busy),
    .sdr              (bus)
  );

  always #5 clk = ~clk;

  // {done, busy, cke, cs_n, ras_n/cas_n/we_n, ba, addr}
  function automatic logic [31:0] pack(input logic d, input logic b, input logic cke,
                                       input logic cs_n, input logic [2:0] cmd,
                                       input logic [1:0] ba, input logic [12:0] addr);
    return {10'd0, d, b, cke, cs_n, cmd, ba, addr};
  endfunction

  function automatic logic [31:0] observed();
    return pack(done, busy, bus.sdr_cke, bus.sdr_cs_n,
                {bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n}, bus.sdr_ba, bus.sdr_addr);
  endfunction

  // Expected pins at cycle k, where cycle 0 is the first cycle with reset low.
  function automatic logic [31:0] exp_at(input int k);
    if (k == 0)               return pack(1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 2'd0, 13'h0000);
    if (k == 601)             return pack(1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 2'd0, 13'h0400);
    if (k == 604 || k == 611) return pack(1'b0, 1'b1, 1'b1, 1'b0, 3'b001, 2'd0, 13'h0000);
    if (k == 618)             return pack(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 2'd0, 13'h0033);
`ifdef SDR_INIT_EMR_EN
    if (k == 620)             return pack(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 2'd1, 13'h0002);
    if (k >= 622)             return pack(1'b1, 1'b0, 1'b1, 1'b0, 3'b111, 2'd0, 13'h0000);
`else
    if (k >= 620)             return pack(1'b1, 1'b0, 1'b1, 1'b0, 3'b111, 2'd0, 13'h0000);
`endif
    return pack(1'b0, 1'b1, 1'b1, 1'b0, 3'b111, 2'd0, 13'h0000);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance one cycle at a time and check cycles k0..k1 of the timeline.
  task automatic walk(input string run, input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      step();
      check_eq($sformatf("%s_c%0d", run, k), observed(), exp_at(k));
    end
  endtask

  initial begin
    // Reset held, then the baseline power-up sequence.
    repeat (3) step();
    check_eq("in_reset", observed(), exp_at(0));
    rst = 1'b0;
    check_eq("A_c0", observed(), exp_at(0));
    walk("A", 1, 630);

    // init_req in DONE: PRE next cycle, WAIT_PWR skipped, done again 19 later.
    init_req = 1'b1;
    walk("B", 601, 601);
    init_req = 1'b0;
    walk("B", 602, 630);

    // Reset and init_req together in DONE: reset wins.
    rst      = 1'b1;
    init_req = 1'b1;
    walk("P", 0, 0);
    rst      = 1'b0;
    init_req = 1'b0;
    walk("P", 1, 606);

    // init_req during WAIT_RFC is ignored.
    init_req = 1'b1;
    walk("P", 607, 607);
    init_req = 1'b0;
    walk("P", 608, 609);

    // One-cycle reset mid WAIT_RFC, full restart; init_req in WAIT_PWR ignored.
    rst = 1'b1;
    walk("R", 0, 0);
    rst = 1'b0;
    walk("R", 1, 300);
    init_req = 1'b1;
    walk("R", 301, 301);
    init_req = 1'b0;
    walk("R", 302, 630);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
